// File: rtl/wts_timer_pkg.sv
// Shared definitions for the WTS timer trigger generator: width defaults and
// the per-channel FSM state encoding.
package wts_timer_pkg;

  localparam int unsigned PERIOD_W_DEF = 12;
  localparam int unsigned ADDR_W_DEF   = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/wts_timer_trigger_ch.sv
// Single programmable interval timer channel: IDLE/RUN FSM, reload down-counter,
// sequence address counter and registered one-cycle trigger.
module wts_timer_trigger_ch
  import wts_timer_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                i_adv,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_oneshot,
  output logic                o_trigger,
  output logic [ADDR_W-1:0]   o_address,
  output logic                o_busy,
  output logic                o_expire
);

  state_t              r_state, w_state_nxt;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr_cnt, w_addr_cnt_nxt;
  logic [ADDR_W-1:0]   r_address, w_address_nxt;
  logic                r_trigger, w_trigger_nxt;
  logic                w_expire;

  // Stop and start both pre-empt expiry, so a same-cycle tick can never fire.
  assign w_expire = (r_state == ST_RUN) && i_adv && (r_cnt == '0) && !i_stop && !i_start;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_cnt_nxt = r_addr_cnt;
    w_address_nxt  = r_address;
    w_trigger_nxt  = 1'b0;
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (i_start) begin
      w_state_nxt    = ST_RUN;
      w_cnt_nxt      = i_period;
      w_addr_cnt_nxt = '0;
    end else if (w_expire) begin
      w_trigger_nxt  = 1'b1;
      w_address_nxt  = r_addr_cnt;
      w_addr_cnt_nxt = r_addr_cnt + ADDR_W'(1);
      w_cnt_nxt      = i_period;
      if (i_oneshot) w_state_nxt = ST_IDLE;
    end else if ((r_state == ST_RUN) && i_adv) begin
      w_cnt_nxt = r_cnt - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr_cnt <= '0;
      r_address  <= '0;
      r_trigger  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr_cnt <= w_addr_cnt_nxt;
      r_address  <= w_address_nxt;
      r_trigger  <= w_trigger_nxt;
    end
  end

  assign o_trigger = r_trigger;
  assign o_address = r_address;
  assign o_busy    = (r_state == ST_RUN);
  assign o_expire  = w_expire;

endmodule

// File: rtl/wts_timer_trigger_gen.sv
// Two-channel WTS timer trigger source. Define WTS_TIMER_CASCADE_EN to let
// timer2 count timer1 expiries when reg_timer2_cascade=1.
module wts_timer_trigger_gen
  import wts_timer_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                tick,
  input  logic [PERIOD_W-1:0] reg_timer1_period,
  input  logic                reg_timer1_start,
  input  logic                reg_timer1_stop,
  input  logic                reg_timer1_oneshot,
  input  logic [PERIOD_W-1:0] reg_timer2_period,
  input  logic                reg_timer2_start,
  input  logic                reg_timer2_stop,
  input  logic                reg_timer2_oneshot,
  input  logic                reg_timer2_cascade,
  output logic                timer1_trigger,
  output logic [ADDR_W-1:0]   timer1_address,
  output logic                timer1_busy,
  output logic                timer2_trigger,
  output logic [ADDR_W-1:0]   timer2_address,
  output logic                timer2_busy
);

  logic w_t1_expire;
  logic w_t2_adv;
  logic w_unused_t2_expire;

`ifdef WTS_TIMER_CASCADE_EN
  // Pre-register strobe keeps timer2 aligned to the same edge timer1 reloads on.
  assign w_t2_adv = reg_timer2_cascade ? w_t1_expire : tick;
`else
  logic w_unused_cascade;
  assign w_unused_cascade = reg_timer2_cascade;
  assign w_t2_adv         = tick;
`endif

  wts_timer_trigger_ch #(
    .PERIOD_W (PERIOD_W),
    .ADDR_W   (ADDR_W)
  ) u_timer1 (
    .clk       (clk),
    .nreset    (nreset),
    .i_adv     (tick),
    .i_period  (reg_timer1_period),
    .i_start   (reg_timer1_start),
    .i_stop    (reg_timer1_stop),
    .i_oneshot (reg_timer1_oneshot),
    .o_trigger (timer1_trigger),
    .o_address (timer1_address),
    .o_busy    (timer1_busy),
    .o_expire  (w_t1_expire)
  );

  wts_timer_trigger_ch #(
    .PERIOD_W (PERIOD_W),
    .ADDR_W   (ADDR_W)
  ) u_timer2 (
    .clk       (clk),
    .nreset    (nreset),
    .i_adv     (w_t2_adv),
    .i_period  (reg_timer2_period),
    .i_start   (reg_timer2_start),
    .i_stop    (reg_timer2_stop),
    .i_oneshot (reg_timer2_oneshot),
    .o_trigger (timer2_trigger),
    .o_address (timer2_address),
    .o_busy    (timer2_busy),
    .o_expire  (w_unused_t2_expire)
  );

endmodule

// File: tb/tb_wts_timer_trigger_gen.sv
// Directed self-checking bench for wts_timer_trigger_gen; expectations for the
// cascade case follow whether WTS_TIMER_CASCADE_EN is defined.
module tb_wts_timer_trigger_gen;

  localparam int unsigned PW = 12;
  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          nreset;
  logic          tick;
  logic [PW-1:0] t1_period, t2_period;
  logic          t1_start, t1_stop, t1_oneshot;
  logic          t2_start, t2_stop, t2_oneshot, t2_cascade;
  logic          t1_trig, t1_busy, t2_trig, t2_busy;
  logic [AW-1:0] t1_addr, t2_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wts_timer_trigger_gen #(
    .PERIOD_W (PW),
    .ADDR_W   (AW)
  ) dut (
    .clk                (clk),
    .nreset             (nreset),
    .tick               (tick),
    .reg_timer1_period  (t1_period),
    .reg_timer1_start   (t1_start),
    .reg_timer1_stop    (t1_stop),
    .reg_timer1_oneshot (t1_oneshot),
    .reg_timer2_period  (t2_period),
    .reg_timer2_start   (t2_start),
    .reg_timer2_stop    (t2_stop),
    .reg_timer2_oneshot (t2_oneshot),
    .reg_timer2_cascade (t2_cascade),
    .timer1_trigger     (t1_trig),
    .timer1_address     (t1_addr),
    .timer1_busy        (t1_busy),
    .timer2_trigger     (t2_trig),
    .timer2_address     (t2_addr),
    .timer2_busy        (t2_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start1(input logic [PW-1:0] p);
    t1_period = p;
    t1_start  = 1'b1;
    step();
    t1_start  = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {16'd0, t1_trig, t1_addr, t1_busy, t2_trig, t2_addr, t2_busy};
  endfunction

  initial begin
    int n_t2;
    bit casc;
`ifdef WTS_TIMER_CASCADE_EN
    casc = 1'b1;
`else
    casc = 1'b0;
`endif
    nreset = 1'b0; tick = 1'b1;
    t1_period = '0; t1_start = 0; t1_stop = 0; t1_oneshot = 0;
    t2_period = '0; t2_start = 0; t2_stop = 0; t2_oneshot = 0; t2_cascade = 0;
    #3;
    check("reset_outputs", all_outs(), 32'd0);
    step(); step();
    @(negedge clk) nreset = 1'b1;
    step();
    check("idle_after_reset", all_outs(), 32'd0);

    // Periodic, P=3: triggers after edges 4, 8, 12 with addresses 0,1,2.
    start1(12'd3);
    check("per_busy_start", {31'd0, t1_busy}, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("per_trig_k%0d", k), {31'd0, t1_trig}, {31'd0, (k % 4 == 0)});
      check($sformatf("per_busy_k%0d", k), {31'd0, t1_busy}, 32'd1);
      if (k % 4 == 0) check($sformatf("per_addr_k%0d", k), {25'd0, t1_addr}, k / 4 - 1);
    end
    t1_stop = 1'b1; step(); t1_stop = 1'b0;
    check("stop_busy", {31'd0, t1_busy}, 32'd0);
    check("stop_addr_hold", {25'd0, t1_addr}, 32'd2);
    check("stop_no_trig", {31'd0, t1_trig}, 32'd0);

    // One-shot, P=2: single trigger after third tick, busy drops with it.
    t1_oneshot = 1'b1;
    start1(12'd2);
    for (int k = 1; k <= 22; k++) begin
      step();
      check($sformatf("os_trig_k%0d", k), {31'd0, t1_trig}, {31'd0, (k == 3)});
      check($sformatf("os_busy_k%0d", k), {31'd0, t1_busy}, {31'd0, (k < 3)});
    end
    check("os_addr", {25'd0, t1_addr}, 32'd0);
    t1_oneshot = 1'b0;

    // P=0 for 130 ticks: trigger every tick, address wraps after 127.
    start1(12'd0);
    for (int k = 1; k <= 130; k++) begin
      step();
      check($sformatf("wrap_trig_k%0d", k), {31'd0, t1_trig}, 32'd1);
      check($sformatf("wrap_addr_k%0d", k), {25'd0, t1_addr}, (k - 1) % 128);
    end

    // Start and stop together: stop wins.
    t1_start = 1'b1; t1_stop = 1'b1; step(); t1_start = 1'b0; t1_stop = 1'b0;
    check("ss_busy", {31'd0, t1_busy}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("ss_idle_k%0d", k), {30'd0, t1_trig, t1_busy}, 32'd0);
    end

    // Stop on the expiry tick suppresses the trigger; address holds 1.
    start1(12'd2);
    step(); step();
    t1_stop = 1'b1; step(); t1_stop = 1'b0;
    check("soe_trig", {31'd0, t1_trig}, 32'd0);
    check("soe_busy", {31'd0, t1_busy}, 32'd0);
    check("soe_addr", {25'd0, t1_addr}, 32'd1);
    step();
    check("soe_trig_after", {31'd0, t1_trig}, 32'd0);

    // Restart mid-count with P=4: next trigger 5 ticks later, address 0.
    start1(12'd9);
    step(); step(); step();
    start1(12'd4);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("rs_trig_k%0d", k), {31'd0, t1_trig}, {31'd0, (k == 5)});
    end
    check("rs_addr", {25'd0, t1_addr}, 32'd0);

    // Asynchronous reset mid-count clears everything immediately.
    start1(12'd5);
    step(); step(); step();
    check("rst_busy_before", {31'd0, t1_busy}, 32'd1);
    #2 nreset = 1'b0;
    #1 check("rst_async", all_outs(), 32'd0);
    step();
    check("rst_held", all_outs(), 32'd0);
    @(negedge clk) nreset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("rst_after_k%0d", k), {30'd0, t1_trig, t1_busy}, 32'd0);
    end

    // Timer1 P=1 and timer2 P=2 started together, cascade select on.
    t2_period = 12'd2; t2_cascade = 1'b1;
    t1_period = 12'd1;
    t1_start = 1'b1; t2_start = 1'b1; step(); t1_start = 1'b0; t2_start = 1'b0;
    n_t2 = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      check($sformatf("cas_t1_k%0d", k), {31'd0, t1_trig}, {31'd0, (k % 2 == 0)});
      check($sformatf("cas_t2_k%0d", k), {31'd0, t2_trig},
            {31'd0, (casc ? (k % 6 == 0) : (k % 3 == 0))});
      if (casc ? (k % 6 == 0) : (k % 3 == 0)) n_t2++;
    end
    check("cas_t2_addr", {25'd0, t2_addr}, n_t2 - 1);
    check("cas_t2_busy", {31'd0, t2_busy}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wts_timer_trigger_gen.md
Name: wts_timer_trigger_gen

Overview:
Trigger source that drives the timer interrupt/status block. It contains two independent programmable interval timers. Each timer counts prescaled ticks and, on expiry, emits a one-cycle trigger pulse together with a 7-bit sequence address. The block sits between the WTS register file and the timer interrupt/status logic, and its outputs connect directly to timer1/2_trigger and timer1/2_address.

Parameters:
PERIOD_W, 12, width of each reload period and its down-counter
ADDR_W, 7, width of the sequence address and its counter

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous reset, active-low
tick  in  1  prescaler enable; counters advance only on cycles where tick=1
reg_timer1_period  in  PERIOD_W  timer1 reload value; sampled at start and at every reload
reg_timer1_start  in  1  one-cycle pulse; (re)starts timer1
reg_timer1_stop  in  1  one-cycle pulse; stops timer1
reg_timer1_oneshot  in  1  1 = stop after first trigger; 0 = periodic
reg_timer2_period  in  PERIOD_W  timer2 reload value
reg_timer2_start  in  1  timer2 start pulse
reg_timer2_stop  in  1  timer2 stop pulse
reg_timer2_oneshot  in  1  timer2 one-shot select
reg_timer2_cascade  in  1  timer2 clock-source select (see Optional Feature)
timer1_trigger  out  1  registered one-cycle expiry pulse
timer1_address  out  ADDR_W  sequence number of the latest timer1 trigger
timer1_busy  out  1  timer1 is in RUN
timer2_trigger  out  1  timer2 expiry pulse
timer2_address  out  ADDR_W  sequence number of the latest timer2 trigger
timer2_busy  out  1  timer2 is in RUN

Behaviour:
- Reset: all outputs are 0, both FSMs are IDLE, counters and address counters are 0. Reset applies immediately from any state, including mid-count.
- Per-timer FSM has two states, IDLE and RUN. busy = (state == RUN).
- Start (any state):
  - cnt <= period, addr_cnt <= 0, state <= RUN.
  - A tick in the same cycle as start is ignored.
  - A start while already in RUN restarts the timer from scratch.
- Stop:
  - state <= IDLE; no trigger is issued.
  - If stop and start arrive in the same cycle, stop wins.
- RUN with tick=1 and cnt != 0: cnt <= cnt - 1.
- RUN with tick=1 and cnt == 0:
  - trigger <= 1 for the next cycle only.
  - address <= addr_cnt, then addr_cnt <= addr_cnt + 1, wrapping 127 -> 0.
  - cnt <= current period.
  - If oneshot=1, state <= IDLE in the same edge.
- Latency: with period P, the first trigger fires on the (P+1)th tick after start. The trigger is visible in the cycle after that tick.
- P=0: a trigger fires on every tick.
- Periodic spacing between triggers is P+1 ticks. Changing period mid-run takes effect at the next reload only.
- trigger is 0 on every cycle not described above; it is never asserted for two consecutive cycles unless the tick and P=0 conditions repeat.
- address holds its value between triggers and across stop and IDLE. It is not cleared by start; the first trigger after a start reports address 0.
- Trigger on the same cycle as stop: stop wins, and the trigger is suppressed.
- IDLE: tick is ignored and trigger stays 0.

Optional Feature:
- Macro: WTS_TIMER_CASCADE_EN.
- Defined, with reg_timer2_cascade=1: timer2 advances on timer1 expiry events (the internal pre-register expiry strobe) instead of on tick, giving a 24-bit-class combined interval.
- Defined, with reg_timer2_cascade=0: timer2 uses tick.
- Not defined: the reg_timer2_cascade port remains but is ignored, and timer2 always uses tick.

Decomposition:
- Shared package wts_timer_pkg holds:
  - PERIOD_W and ADDR_W defaults.
  - The FSM state encoding (ST_IDLE=0, ST_RUN=1).
- Natural sub-module: wts_timer_trigger_ch, a single channel with FSM, down-counter, address counter and registered trigger. The top instantiates it twice and adds the cascade mux.

Test Plan:
- Reset mid-run: start timer1 with P=5, assert nreset low after 3 ticks -> all outputs are 0 immediately; no trigger after release.
- Periodic timing: P=3, tick every cycle, start at cycle 0 -> trigger pulses at cycles 5, 9, 13 with addresses 0, 1, 2; busy stays 1.
- One-shot: P=2, oneshot=1 -> exactly one trigger (address 0); busy drops in the cycle the trigger asserts; no further triggers over 20 ticks.
- Address wrap: P=0, run 130 ticks -> triggers on all 130 ticks; address sequence is 0..127, 0, 1.
- Simultaneous events:
  - start and stop in the same cycle -> stays IDLE.
  - stop on the expiry tick -> no trigger.
  - restart mid-count with P=4 -> the next trigger arrives 5 ticks after the restart, with address 0.
- WTS_TIMER_CASCADE_EN, cascade=1: timer1 P=1, timer2 P=2 -> timer2 triggers once per 3 timer1 triggers (every 6 ticks). The same stimulus with the macro undefined gives a timer2 trigger every 3 ticks.
